// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between the MEM stage (priority) and an
// external burst port, with a starvation counter guaranteeing burst progress.

`ifndef DATA_MEM_ADDR_WIDTH
`define DATA_MEM_ADDR_WIDTH 8
`endif

module data_mem_arbiter #(
    parameter int ADDR_WIDTH   = `DATA_MEM_ADDR_WIDTH,
    parameter int LEN_WIDTH    = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [15:0]           cpu_addr,
    input  logic [15:0]           cpu_wdata,
    output logic [15:0]           cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  ext_req,
    input  logic                  ext_we,
    input  logic [ADDR_WIDTH-1:0] ext_addr,
    input  logic [LEN_WIDTH-1:0]  ext_len,
    output logic                  ext_busy,
    output logic                  ext_wready,
    input  logic [15:0]           ext_wdata,
    output logic                  ext_rvalid,
    output logic [15:0]           ext_rdata,
    output logic                  ext_done,
    output logic [15:0]           mem_access_addr,
    output logic                  mem_write_en,
    output logic [15:0]           mem_write_data,
    input  logic [15:0]           mem_read_data
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST,
        ST_DONE
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t                state_q, state_d;
    logic                  dir_q, dir_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [3:0]            starve_cnt_q, starve_cnt_d;
    logic [15:0]           ext_rdata_q, ext_rdata_d;
    logic                  ext_rvalid_q, ext_rvalid_d;
    logic                  ext_slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            dir_q        <= 1'b0;
            cur_addr_q   <= '0;
            remaining_q  <= '0;
            starve_cnt_q <= '0;
            ext_rdata_q  <= '0;
            ext_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            cur_addr_q   <= cur_addr_d;
            remaining_q  <= remaining_d;
            starve_cnt_q <= starve_cnt_d;
            ext_rdata_q  <= ext_rdata_d;
            ext_rvalid_q <= ext_rvalid_d;
        end
    end

    // The burst gets the memory whenever the CPU is quiet, or once the CPU
    // has won STARVE_LIMIT cycles in a row.
    assign ext_slot = (state_q == ST_BURST) &&
                      (!cpu_req || (starve_cnt_q == STARVE_MAX));

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        cur_addr_d   = cur_addr_q;
        remaining_d  = remaining_q;
        starve_cnt_d = starve_cnt_q;
        ext_rdata_d  = ext_rdata_q;
        ext_rvalid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ext_req) begin
                    dir_d        = ext_we;
                    cur_addr_d   = ext_addr;
                    remaining_d  = ext_len;
                    starve_cnt_d = '0;
                    state_d      = ST_BURST;
                end
            end
            ST_BURST: begin
                if (ext_slot) begin
                    cur_addr_d   = cur_addr_q + 1'b1;
                    starve_cnt_d = '0;
                    if (!dir_q) begin
                        ext_rdata_d  = mem_read_data;
                        ext_rvalid_d = 1'b1;
                    end
                    if (remaining_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        remaining_d = remaining_q - 1'b1;
                    end
                end else if (starve_cnt_q != STARVE_MAX) begin
                    starve_cnt_d = starve_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_access_addr = cpu_addr;
        mem_write_en    = cpu_req & cpu_we;
        mem_write_data  = cpu_wdata;
        cpu_stall       = 1'b0;
        ext_wready      = 1'b0;
        if (ext_slot) begin
            mem_access_addr = 16'(cur_addr_q);
            mem_write_en    = dir_q;
            mem_write_data  = ext_wdata;
            cpu_stall       = cpu_req;
            ext_wready      = dir_q;
        end
    end

    assign cpu_rdata  = mem_read_data;
    assign ext_busy   = (state_q == ST_BURST) || (state_q == ST_DONE);
    assign ext_done   = (state_q == ST_DONE);
    assign ext_rvalid = ext_rvalid_q;
    assign ext_rdata  = ext_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomised and directed checks of data_mem_arbiter against a per-cycle
// behavioural model of the arbitration rules and a reference memory image.

`timescale 1ns/1ps

module tb_data_mem_arbiter;

    localparam int AW    = 8;
    localparam int LW    = 4;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req, cpu_we;
    logic [15:0]   cpu_addr, cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic          ext_req, ext_we;
    logic [AW-1:0] ext_addr;
    logic [LW-1:0] ext_len;
    logic          ext_busy, ext_wready, ext_rvalid, ext_done;
    logic [15:0]   ext_wdata, ext_rdata;
    logic [15:0]   mem_access_addr, mem_write_data, mem_read_data;
    logic          mem_write_en;
    logic          init_mem;

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];

    int total = 0;
    int bad   = 0;

    data_mem_arbiter #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_len(ext_len),
        .ext_busy(ext_busy), .ext_wready(ext_wready), .ext_wdata(ext_wdata),
        .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata), .ext_done(ext_done),
        .mem_access_addr(mem_access_addr), .mem_write_en(mem_write_en),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int a);
        return 16'(a * 7 + 'h1234);
    endfunction

    // Behavioural single-port memory: combinational read, write at the edge.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 65536; i++) mem[i] <= init_val(i);
        end else if (mem_write_en) begin
            mem[mem_access_addr] <= mem_write_data;
        end
    end
    assign mem_read_data = mem[mem_access_addr];

    // Model: phase 0 idle, 1 burst, 2 done; words left and CPU wins since last slot.
    int          m_phase, m_left, m_wait;
    logic [7:0]  m_addr;
    logic        m_we;
    logic        exp_rvalid;
    logic [15:0] exp_rdata;
    logic        cyc_slot;
    int          burst_cyc, since_accept, words_sent, wready_cnt, done_at;
    bit          seq_wdata;
    int          stall_pos[$];
    logic [15:0] rd_seen[$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase    = 0;
        m_left     = 0;
        m_wait     = 0;
        m_addr     = '0;
        m_we       = 1'b0;
        exp_rvalid = 1'b0;
        exp_rdata  = '0;
    endtask

    task automatic clear_marks();
        stall_pos.delete();
        rd_seen.delete();
        wready_cnt = 0;
        done_at    = -1;
    endtask

    task automatic check_cycle();
        cyc_slot = (m_phase == 1) && (!cpu_req || m_wait == LIMIT);
        checkOutput("cpu_stall", 32'(cpu_stall), 32'(cyc_slot && cpu_req));
        checkOutput("ext_wready", 32'(ext_wready), 32'(cyc_slot && m_we));
        checkOutput("ext_busy", 32'(ext_busy), 32'(m_phase != 0));
        checkOutput("ext_done", 32'(ext_done), 32'(m_phase == 2));
        checkOutput("ext_rvalid", 32'(ext_rvalid), 32'(exp_rvalid));
        checkOutput("ext_rdata", 32'(ext_rdata), 32'(exp_rdata));
        if (cyc_slot) begin
            checkOutput("mem_addr_ext", 32'(mem_access_addr), 32'({8'h00, m_addr}));
            checkOutput("mem_we_ext", 32'(mem_write_en), 32'(m_we));
            if (m_we) checkOutput("mem_wdata_ext", 32'(mem_write_data), 32'(ext_wdata));
        end else begin
            checkOutput("mem_addr_cpu", 32'(mem_access_addr), 32'(cpu_addr));
            checkOutput("mem_we_cpu", 32'(mem_write_en), 32'(cpu_req && cpu_we));
            if (cpu_req && cpu_we) checkOutput("mem_wdata_cpu", 32'(mem_write_data), 32'(cpu_wdata));
            if (cpu_req && !cpu_we) checkOutput("cpu_rdata", 32'(cpu_rdata), 32'(ref_mem[cpu_addr]));
        end
        if (m_phase == 1 && cpu_stall) stall_pos.push_back(burst_cyc);
        if (ext_rvalid) rd_seen.push_back(ext_rdata);
        if (ext_wready) wready_cnt++;
        if (ext_done) done_at = since_accept;
    endtask

    task automatic update_model();
        if (cyc_slot) begin
            if (m_we) begin
                ref_mem[{8'h00, m_addr}] = ext_wdata;
                words_sent++;
            end
        end else if (cpu_req && cpu_we) begin
            ref_mem[cpu_addr] = cpu_wdata;
        end
        exp_rvalid = cyc_slot && !m_we;
        if (exp_rvalid) exp_rdata = ref_mem[{8'h00, m_addr}];
        since_accept++;
        case (m_phase)
            0: if (ext_req) begin
                m_phase      = 1;
                m_addr       = ext_addr;
                m_left       = int'(ext_len) + 1;
                m_we         = ext_we;
                m_wait       = 0;
                since_accept = 1;
                burst_cyc    = 0;
                words_sent   = 0;
            end
            1: begin
                burst_cyc++;
                if (cyc_slot) begin
                    m_addr = m_addr + 8'd1;
                    m_wait = 0;
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end else if (m_wait < LIMIT) begin
                    m_wait++;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic applyStimulus(input logic cr, input logic cw, input logic [15:0] ca,
                                 input logic [15:0] cd, input logic er, input logic ew,
                                 input logic [AW-1:0] ea, input logic [LW-1:0] el);
        cpu_req   = cr;
        cpu_we    = cw;
        cpu_addr  = ca;
        cpu_wdata = cd;
        ext_req   = er;
        ext_we    = ew;
        ext_addr  = ea;
        ext_len   = el;
        ext_wdata = seq_wdata ? 16'(16'h00A0 + words_sent) : 16'($urandom);
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic idle_until_free(input string tag);
        int n = 0;
        while (m_phase != 0 && n < 60) begin
            applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, '0, '0);
            n++;
        end
        if (m_phase != 0) checkOutput(tag, 32'(m_phase), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        init_mem = 1'b1;
        seq_wdata = 1'b0;
        words_sent = 0;
        burst_cyc = 0;
        since_accept = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ext_req = 0; ext_we = 0; ext_addr = 0; ext_len = 0; ext_wdata = 0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);
        model_reset();
        clear_marks();
        repeat (2) @(posedge clk);
        #1 init_mem = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", 32'(ext_busy), 32'd0);
        checkOutput("rst_rvalid", 32'(ext_rvalid), 32'd0);
        checkOutput("rst_rdata", 32'(ext_rdata), 32'd0);
        checkOutput("rst_done", 32'(ext_done), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Uncontended write burst of four words at address 5.
        seq_wdata = 1'b1;
        clear_marks();
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 8'd5, 4'd3);
        idle_until_free("t1_timeout");
        checkOutput("t1_wready_cnt", 32'(wready_cnt), 32'd4);
        checkOutput("t1_done_cycle", 32'(done_at), 32'd5);
        for (int i = 0; i < 4; i++) checkOutput("t1_mem", 32'(mem[5 + i]), 32'(16'h00A0 + i));
        seq_wdata = 1'b0;

        // Read burst wrapping from the top of the address space.
        clear_marks();
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 8'd254, 4'd2);
        idle_until_free("t2_timeout");
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, '0, '0);
        checkOutput("t2_rd_count", 32'(rd_seen.size()), 32'd3);
        if (rd_seen.size() == 3) begin
            checkOutput("t2_rd0", 32'(rd_seen[0]), 32'(init_val(254)));
            checkOutput("t2_rd1", 32'(rd_seen[1]), 32'(init_val(255)));
            checkOutput("t2_rd2", 32'(rd_seen[2]), 32'(init_val(0)));
        end

        // CPU loads every cycle; the burst only progresses through starvation slots.
        clear_marks();
        applyStimulus(1'b1, 1'b0, 16'(300), 16'h0, 1'b1, 1'b1, 8'd100, 4'd1);
        for (int n = 0; n < 40 && m_phase != 0; n++)
            applyStimulus(1'b1, 1'b0, 16'($urandom_range(0, 511)), 16'h0, 1'b0, 1'b0, '0, '0);
        if (m_phase != 0) checkOutput("t3_timeout", 32'(m_phase), 32'd0);
        checkOutput("t3_stall_count", 32'(stall_pos.size()), 32'd2);
        if (stall_pos.size() == 2) begin
            checkOutput("t3_slot0", 32'(stall_pos[0]), 32'd4);
            checkOutput("t3_slot1", 32'(stall_pos[1]), 32'd9);
        end

        // CPU store and burst request in the same idle cycle.
        clear_marks();
        applyStimulus(1'b1, 1'b1, 16'd10, 16'hBEEF, 1'b1, 1'b0, 8'd20, 4'd0);
        idle_until_free("t4_timeout");
        checkOutput("t4_mem10", 32'(mem[10]), 32'h0000BEEF);
        checkOutput("t4_done_cycle", 32'(done_at), 32'd2);

        // Asynchronous reset after two of eight burst words.
        seq_wdata = 1'b1;
        clear_marks();
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 8'd40, 4'd7);
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, '0, '0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_busy", 32'(ext_busy), 32'd0);
        checkOutput("rst_mid_wready", 32'(ext_wready), 32'd0);
        checkOutput("rst_mid_stall", 32'(cpu_stall), 32'd0);
        checkOutput("rst_mid_done", 32'(ext_done), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        seq_wdata = 1'b0;
        repeat (3) applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, '0, '0);
        checkOutput("t6_no_done", 32'(done_at), 32'hFFFFFFFF);
        checkOutput("t6_mem40", 32'(mem[40]), 32'h000000A0);
        checkOutput("t6_mem41", 32'(mem[41]), 32'h000000A1);
        checkOutput("t6_mem42", 32'(mem[42]), 32'(init_val(42)));
        clear_marks();
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 8'd60, 4'd1);
        idle_until_free("t6_timeout");
        checkOutput("t6_done_cycle", 32'(done_at), 32'd3);

        // Randomised traffic on both ports.
        for (int n = 0; n < 1500; n++) begin
            applyStimulus($urandom_range(0, 99) < 60, 1'($urandom), 16'($urandom_range(0, 511)),
                          16'($urandom), $urandom_range(0, 99) < 20, 1'($urandom),
                          AW'($urandom), LW'($urandom));
        end
        idle_until_free("rand_timeout");
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 512; i++) checkOutput("final_mem", 32'(mem[i]), 32'(ref_mem[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
